// File: rtl/dot8_mac.sv
// ============================================================================
// dot8_mac -- sequential 8-bit dot-product engine around mul8x8
//
// Accepts a burst of len+1 unsigned 8-bit operand pairs over a valid/ready
// handshake. Each pair is registered into the multiplier (stage 1). The
// 16-bit product is registered (stage 2) and then added to the accumulator.
// The final sum is flagged by a one-cycle done pulse.
//
// Configuration macro:
//   DOT8_MAC_SAT_EN  defined   -> acc_out clamps to 2^ACC_W-1 on overflow
//                    undefined -> acc_out wraps modulo 2^ACC_W
//   ovf is set on overflow in both builds.
//
// Parameters:
//   ACC_W    accumulator / result width (16..32)
//   LEN_W    width of len; a burst is 1..2^LEN_W pairs
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begins a burst (sampled only in IDLE)
//   len       burst length minus one (sampled with start)
//   in_valid  x/y carry a valid pair
//   in_ready  block accepts a pair this cycle
//   x, y      unsigned operands
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle pulse when acc_out holds the final sum
//   acc_out   accumulated sum, held until the next accepted start
//   ovf       sticky overflow flag for the current burst
//
// Also contains mul8x8, the 8x8 unsigned combinational multiplier.
// ============================================================================

module mul8x8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   assign p = 16'(a) * 16'(b);
endmodule

module dot8_mac #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       x,
   input  logic [7:0]       y,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [LEN_W:0]   remaining;   // one extra bit so 2^LEN_W pairs fit
   logic [7:0]       x1;
   logic [7:0]       y1;
   logic             v1;
   logic [15:0]      prod;
   logic [15:0]      p;
   logic             v2;
   logic             xfer;
   logic             start_ok;
   logic [ACC_W:0]   sum;         // MSB is the carry out of the accumulator
   logic [ACC_W-1:0] acc_next;

   // in_ready depends only on state and remaining, never on in_valid.
   assign in_ready = (state == S_RUN) && (remaining != '0);
   assign xfer     = in_valid && in_ready;
   assign start_ok = (state == S_IDLE) && start;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state is written with <= only, so every register sees
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_RUN;
                  remaining <= (LEN_W+1)'(len) + (LEN_W+1)'(1);
               end
            end
            S_RUN: begin
               if (xfer) begin
                  remaining <= remaining - (LEN_W+1)'(1);
                  if (remaining == (LEN_W+1)'(1))
                     state <= S_DRAIN;
               end
            end
            // The final product is in stage 2 with nothing behind it: it is
            // accumulated on this edge, so done follows.
            S_DRAIN: begin
               if (v2 && !v1)
                  state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- pipeline
   mul8x8 u_mul (
      .a (x1),
      .b (y1),
      .p (prod)
   );

   // NOTE: the datapath registers are reset too, so an aborted burst leaves
   // no stale operands or products behind a cleared valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1 <= '0;
         y1 <= '0;
         v1 <= 1'b0;
         p  <= '0;
         v2 <= 1'b0;
      end else begin
         v1 <= xfer;              // no transfer -> a bubble enters stage 1
         if (xfer) begin
            x1 <= x;
            y1 <= y;
         end
         v2 <= v1;
         if (v1)
            p <= prod;
      end
   end

   // -------------------------------------------------------- accumulator
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sum      = {1'b0, acc_out} + (ACC_W+1)'(p);
      acc_next = sum[ACC_W-1:0];
`ifdef DOT8_MAC_SAT_EN
      // Once saturated, stay pinned at the maximum for the rest of the burst.
      if (sum[ACC_W] || ovf)
         acc_next = '1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out <= '0;
         ovf     <= 1'b0;
      end else if (start_ok) begin
         acc_out <= '0;
         ovf     <= 1'b0;
      end else if (v2) begin
         acc_out <= acc_next;
         if (sum[ACC_W])
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dot8_mac.sv
// ============================================================================
// tb_dot8_mac -- self-checking bench for dot8_mac
//
// Two instances share one stimulus stream: u_a at the default ACC_W=24 and
// u_b at ACC_W=16 so that overflow (wrap or saturate, by DOT8_MAC_SAT_EN)
// is exercised. Each burst's expected sum is the plain arithmetic sum of
// products, reduced to the instance width by the overflow rule.
// ============================================================================

module tb_dot8_mac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  len = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  x = '0;
   logic [7:0]  y = '0;

   logic        rdy_a, busy_a, done_a, ovf_a;
   logic [23:0] acc_a;
   logic        rdy_b, busy_b, done_b, ovf_b;
   logic [15:0] acc_b;

   int n_cmp = 0;
   int n_err = 0;
   int rdy_cnt = 0;

   int bx[$];
   int by[$];
   int bgap[$];

   always #5 clk = ~clk;

   dot8_mac #(.ACC_W(24), .LEN_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(rdy_a), .x(x), .y(y),
      .busy(busy_a), .done(done_a), .acc_out(acc_a), .ovf(ovf_a)
   );

   dot8_mac #(.ACC_W(16), .LEN_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(rdy_b), .x(x), .y(y),
      .busy(busy_b), .done(done_b), .acc_out(acc_b), .ovf(ovf_b)
   );

   always @(negedge clk) if (rdy_a) rdy_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
      end
   endtask

   // Expected accumulator value at width w for an exact sum 'full'.
   function automatic logic [31:0] exp_acc(input int w, input longint full);
      longint lim = longint'(1) << w;
      if (full < lim) return 32'(full);
`ifdef DOT8_MAC_SAT_EN
      return 32'(lim - 1);
`else
      return 32'(full % lim);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs the burst held in bx/by/bgap (bgap[i] idle cycles before pair i).
   task automatic run_burst(input bit chk_rdy, input bit poke_start);
      int     n = bx.size();
      longint full = 0;
      int     budget;
      logic [23:0] hold_a;
      for (int i = 0; i < n; i++) full += longint'(bx[i]) * longint'(by[i]);

      rdy_cnt = 0;
      len   = 4'(n - 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy",  32'(busy_a), 32'd1);
      check("start_rdy",   32'(rdy_a),  32'd1);
      check("start_acc_a", 32'(acc_a),  32'd0);
      check("start_ovf_a", 32'(ovf_a),  32'd0);
      check("start_acc_b", 32'(acc_b),  32'd0);
      check("start_ovf_b", 32'(ovf_b),  32'd0);

      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         for (int g = 0; g < bgap[i]; g++) begin
            if (poke_start) begin
               start = 1'b1;
               len   = 4'($urandom);
            end
            tick();
            start = 1'b0;
         end
         in_valid = 1'b1;
         x = 8'(bx[i]);
         y = 8'(by[i]);
         budget = 0;
         while (!rdy_a && budget < 20) begin
            tick();
            budget++;
         end
         if (budget >= 20) check("accept_timeout", 32'(rdy_a), 32'd1);
         tick();
      end
      in_valid = 1'b0;

      // Last pair accepted at edge k; done must be high after edge k+2.
      check("drain_rdy", 32'(rdy_a),  32'd0);
      check("done_k0",   32'(done_a), 32'd0);
      tick();
      check("done_k1",   32'(done_a), 32'd0);
      tick();
      check("done_k2_a", 32'(done_a), 32'd1);
      check("done_k2_b", 32'(done_b), 32'd1);
      check("acc_a",     32'(acc_a),  exp_acc(24, full));
      check("ovf_a",     32'(ovf_a),  32'(full >= (longint'(1) << 24)));
      check("acc_b",     32'(acc_b),  exp_acc(16, full));
      check("ovf_b",     32'(ovf_b),  32'(full >= (longint'(1) << 16)));
      if (chk_rdy) check("rdy_cycles", 32'(rdy_cnt), 32'(n));
      hold_a = acc_a;
      tick();
      check("post_done", 32'(done_a), 32'd0);
      check("post_busy", 32'(busy_a), 32'd0);
      check("acc_hold",  32'(acc_a),  32'(hold_a));
   endtask

   task automatic clear_burst();
      bx.delete();
      by.delete();
      bgap.delete();
   endtask

   task automatic add_pair(input int a, input int b, input int g);
      bx.push_back(a);
      by.push_back(b);
      bgap.push_back(g);
   endtask

   initial begin
      #200us;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen_done;
      bit seen_busy;

      // ---- reset values
      #3;
      check("rst_rdy",  32'(rdy_a),  32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_acc",  32'(acc_a),  32'd0);
      check("rst_ovf",  32'(ovf_a),  32'd0);
      #14 rst_n = 1'b1;
      tick();
      tick();

      // ---- single pair
      clear_burst();
      add_pair(3, 5, 0);
      run_burst(1'b1, 1'b0);

      // ---- full burst at maximum operands
      clear_burst();
      for (int i = 0; i < 16; i++) add_pair(255, 255, 0);
      run_burst(1'b1, 1'b0);

      // ---- stalled burst with ignored start pulses
      clear_burst();
      add_pair(10, 20, 0);
      add_pair(0, 255, 2);
      add_pair(7, 9, 2);
      run_burst(1'b0, 1'b1);

      // ---- overflow at ACC_W=16, immediately followed by a new burst
      clear_burst();
      add_pair(255, 255, 0);
      add_pair(255, 255, 0);
      run_burst(1'b1, 1'b0);
      clear_burst();
      add_pair(1, 2, 0);
      add_pair(3, 4, 0);
      run_burst(1'b1, 1'b0);

      // ---- reset in the middle of a burst
      len   = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      x = 8'd9;
      y = 8'd9;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rdy",  32'(rdy_a),  32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      check("mid_rst_done", 32'(done_a), 32'd0);
      check("mid_rst_acc",  32'(acc_a),  32'd0);
      check("mid_rst_ovf",  32'(ovf_b),  32'd0);
      in_valid = 1'b0;
      #3 rst_n = 1'b1;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         seen_done |= done_a | done_b;
         seen_busy |= busy_a | busy_b;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_idle",    32'(seen_busy), 32'd0);

      // ---- randomized bursts
      for (int b = 0; b < 25; b++) begin
         int  n = $urandom_range(1, 16);
         bit  stall = ($urandom_range(0, 9) < 3);
         clear_burst();
         for (int i = 0; i < n; i++) begin
            int a  = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            int bb = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            int g  = (stall && i > 0) ? $urandom_range(0, 2) : 0;
            add_pair(a, bb, g);
         end
         run_burst(!stall, stall);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
